// File: rtl/tracking_frame_pkg.sv
// rtl/tracking_frame_pkg.sv - shared types and frame constants; TRACKING_FRAME_TX_RANGE_EN adds the range word
package tracking_frame_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_READ_REQ,
        ST_READ_WAIT,
        ST_SEND,
        ST_DONE
    } state_t;

    // Same encoding as the frame collector's error codes.
    typedef enum logic [1:0] {
        ERR_SUCCESS         = 2'd0,
        ERR_READ_TIMEOUT    = 2'd1,
        ERR_REQUEST_DROPPED = 2'd2
    } err_t;

    typedef enum logic [2:0] {
        MODE_NONE    = 3'd0,
        MODE_MCC     = 3'd1,
        MODE_RADAR   = 3'd2,
        MODE_MCR     = 3'd3,
        MODE_PROGRAM = 3'd4
    } mode_t;

    localparam logic [7:0] DEFAULT_HEADER_0 = 8'h55;
    localparam logic [7:0] DEFAULT_HEADER_1 = 8'hAA;
    localparam int HDR_BYTES  = 2;
    localparam int WORD_BYTES = 4;

`ifdef TRACKING_FRAME_TX_RANGE_EN
    localparam int NUM_WORDS = 3;
`else
    localparam int NUM_WORDS = 2;
`endif

    // headers + mode + word bytes + status + checksum
    localparam int FRAME_LEN = HDR_BYTES + 1 + WORD_BYTES * NUM_WORDS + 2;
    localparam int WIDX_W    = $clog2(NUM_WORDS);

    function automatic logic [7:0] word_sum(input logic [31:0] w);
        return w[31:24] + w[23:16] + w[15:8] + w[7:0];
    endfunction

endpackage

// File: rtl/frame_byte_mux.sv
// rtl/frame_byte_mux.sv - selects the frame byte at a given index
module frame_byte_mux
    import tracking_frame_pkg::*;
#(
    parameter logic [7:0] HEADER_0 = DEFAULT_HEADER_0,
    parameter logic [7:0] HEADER_1 = DEFAULT_HEADER_1
) (
    input  logic [4:0]                  byte_idx,
    input  logic [7:0]                  mode,
    input  logic [7:0]                  status,
    input  logic [7:0]                  checksum,
    input  logic [NUM_WORDS-1:0][31:0]  words,
    output logic [7:0]                  frame_byte
);

    always_comb begin
        frame_byte = 8'h00;
        if (byte_idx == 5'd0) begin
            frame_byte = HEADER_0;
        end else if (byte_idx == 5'd1) begin
            frame_byte = HEADER_1;
        end else if (byte_idx == 5'd2) begin
            frame_byte = mode;
        end else if (byte_idx == 5'(FRAME_LEN - 2)) begin
            frame_byte = status;
        end else if (byte_idx == 5'(FRAME_LEN - 1)) begin
            frame_byte = checksum;
        end else begin
            // Word bytes follow the mode byte, most significant byte first.
            for (int w = 0; w < NUM_WORDS; w++) begin
                for (int b = 0; b < WORD_BYTES; b++) begin
                    if (byte_idx == 5'(3 + WORD_BYTES * w + b)) begin
                        frame_byte = words[w][8 * (3 - b) +: 8];
                    end
                end
            end
        end
    end

endmodule

// File: rtl/tracking_frame_tx.sv
// rtl/tracking_frame_tx.sv - reads tracking words from BRAM and sends a checksummed UART frame (TRACKING_FRAME_TX_RANGE_EN)
module tracking_frame_tx
    import tracking_frame_pkg::*;
#(
    parameter logic [7:0] HEADER_0     = DEFAULT_HEADER_0,
    parameter logic [7:0] HEADER_1     = DEFAULT_HEADER_1,
    parameter logic [9:0] ADDR_AZ      = 10'd14,
    parameter logic [9:0] ADDR_EL      = 10'd15,
    parameter logic [9:0] ADDR_RANGE   = 10'd6,
    parameter int         READ_TIMEOUT = 8
) (
    input  logic        system_clk,
    input  logic        reset,
    input  logic        send_request,
    input  logic [2:0]  tracking_mode,
    input  logic [7:0]  status_in,
    output logic        bram_read_run,
    output logic [9:0]  bram_addr,
    input  logic        bram_read_valid,
    input  logic [31:0] bram_rdata,
    output logic        tx_valid,
    input  logic        tx_ready,
    output logic [7:0]  tx_data,
    output logic        busy,
    output logic        frame_done,
    output logic [1:0]  tx_error_bit
);

    localparam logic [4:0]        LAST_BYTE = 5'(FRAME_LEN - 1);
    localparam logic [7:0]        WAIT_LAST = 8'(READ_TIMEOUT - 1);
    localparam logic [WIDX_W-1:0] LAST_WORD = WIDX_W'(NUM_WORDS - 1);

    state_t                    state, state_nxt;
    err_t                      err_q;
    logic [7:0]                mode_q, status_q, checksum_q, wait_cnt;
    logic [WIDX_W-1:0]         word_idx;
    logic [4:0]                byte_idx;
    logic [NUM_WORDS-1:0][31:0] words_q;
    logic [7:0]                frame_byte;

    always_comb begin
        state_nxt = state;
        case (state)
            ST_IDLE:      if (send_request) state_nxt = ST_READ_REQ;
            ST_READ_REQ:  state_nxt = ST_READ_WAIT;
            ST_READ_WAIT: begin
                if (bram_read_valid) begin
                    state_nxt = (word_idx == LAST_WORD) ? ST_SEND : ST_READ_REQ;
                end else if (wait_cnt == WAIT_LAST) begin
                    state_nxt = ST_IDLE;
                end
            end
            ST_SEND:      if (tx_ready && byte_idx == LAST_BYTE) state_nxt = ST_DONE;
            ST_DONE:      state_nxt = ST_IDLE;
            default:      state_nxt = ST_IDLE;
        endcase
    end

    always_ff @(posedge system_clk or negedge reset) begin
        if (!reset) begin
            state      <= ST_IDLE;
            err_q      <= ERR_SUCCESS;
            mode_q     <= 8'h00;
            status_q   <= 8'h00;
            checksum_q <= 8'h00;
            wait_cnt   <= 8'h00;
            word_idx   <= '0;
            byte_idx   <= 5'd0;
            words_q    <= '0;
        end else begin
            state <= state_nxt;
            case (state)
                ST_IDLE: begin
                    if (send_request) begin
                        mode_q     <= {5'b0, tracking_mode};
                        status_q   <= status_in;
                        word_idx   <= '0;
                        // Seed with mode + status; word bytes are added as they arrive.
                        checksum_q <= {5'b0, tracking_mode} + status_in;
                    end
                end
                ST_READ_REQ: wait_cnt <= 8'h00;
                ST_READ_WAIT: begin
                    if (bram_read_valid) begin
                        words_q[word_idx] <= bram_rdata;
                        checksum_q        <= checksum_q + word_sum(bram_rdata);
                        word_idx          <= word_idx + 1'b1;
                        byte_idx          <= 5'd0;
                    end else begin
                        wait_cnt <= wait_cnt + 8'd1;
                        if (wait_cnt == WAIT_LAST) err_q <= ERR_READ_TIMEOUT;
                    end
                end
                ST_SEND: if (tx_ready) byte_idx <= byte_idx + 5'd1;
                ST_DONE: err_q <= ERR_SUCCESS;
                default: ;
            endcase
            // A request during DONE is still a dropped request, so this overrides the clear.
            if (send_request && state != ST_IDLE) err_q <= ERR_REQUEST_DROPPED;
        end
    end

    frame_byte_mux #(
        .HEADER_0 (HEADER_0),
        .HEADER_1 (HEADER_1)
    ) u_mux (
        .byte_idx   (byte_idx),
        .mode       (mode_q),
        .status     (status_q),
        .checksum   (checksum_q),
        .words      (words_q),
        .frame_byte (frame_byte)
    );

    always_comb begin
        bram_addr = 10'd0;
        if (state == ST_READ_REQ || state == ST_READ_WAIT) begin
            if (word_idx == '0)                 bram_addr = ADDR_AZ;
            else if (word_idx == WIDX_W'(1))    bram_addr = ADDR_EL;
            else                                bram_addr = ADDR_RANGE;
        end
    end

    assign bram_read_run = (state == ST_READ_REQ);
    assign tx_valid      = (state == ST_SEND);
    assign tx_data       = (state == ST_SEND) ? frame_byte : 8'h00;
    assign busy          = (state == ST_READ_REQ) || (state == ST_READ_WAIT) || (state == ST_SEND);
    assign frame_done    = (state == ST_DONE);
    assign tx_error_bit  = err_q;

endmodule

// File: tb/tb_tracking_frame_tx.sv
// tb/tb_tracking_frame_tx.sv - self-checking bench for tracking_frame_tx
module tb_tracking_frame_tx;

`ifdef TRACKING_FRAME_TX_RANGE_EN
    localparam int NW = 3;
`else
    localparam int NW = 2;
`endif
    localparam int FLEN = 2 + 1 + 4 * NW + 2;

    logic        system_clk = 1'b0;
    logic        reset = 1'b0;
    logic        send_request = 1'b0;
    logic [2:0]  tracking_mode = 3'd0;
    logic [7:0]  status_in = 8'h00;
    logic        bram_read_run;
    logic [9:0]  bram_addr;
    logic        bram_read_valid = 1'b0;
    logic [31:0] bram_rdata = 32'h0;
    logic        tx_valid;
    logic        tx_ready = 1'b1;
    logic [7:0]  tx_data;
    logic        busy;
    logic        frame_done;
    logic [1:0]  tx_error_bit;

    int tests = 0;
    int fails = 0;

    logic [31:0] mem_az, mem_el, mem_range;
    logic [9:0]  rd_addr;
    bit          bram_on = 1'b1;
    bit          ready_toggle = 1'b0;
    int          cyc = 0;
    logic [7:0]  exp_q[$];
    logic [7:0]  got_q[$];
    logic [7:0]  lit[$];
    int          valid_cycles = 0;
    int          done_cnt = 0;
    logic        stall_prev = 1'b0;
    logic [7:0]  prev_data = 8'h00;

    tracking_frame_tx dut (
        .system_clk      (system_clk),
        .reset           (reset),
        .send_request    (send_request),
        .tracking_mode   (tracking_mode),
        .status_in       (status_in),
        .bram_read_run   (bram_read_run),
        .bram_addr       (bram_addr),
        .bram_read_valid (bram_read_valid),
        .bram_rdata      (bram_rdata),
        .tx_valid        (tx_valid),
        .tx_ready        (tx_ready),
        .tx_data         (tx_data),
        .busy            (busy),
        .frame_done      (frame_done),
        .tx_error_bit    (tx_error_bit)
    );

    always #5 system_clk = ~system_clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    function automatic logic [31:0] bram_word(input logic [9:0] a);
        case (a)
            10'd14:  return mem_az;
            10'd15:  return mem_el;
            10'd6:   return mem_range;
            default: return 32'hDEAD_BEEF;
        endcase
    endfunction

    // Reference frame built straight from the frame layout rules.
    task automatic push_frame(input logic [7:0] mode, input logic [7:0] status);
        logic [7:0]  f[$];
        logic [31:0] w[$];
        logic [7:0]  sum;
        w.push_back(mem_az);
        w.push_back(mem_el);
        if (NW == 3) w.push_back(mem_range);
        f.push_back(8'h55);
        f.push_back(8'hAA);
        f.push_back(mode);
        foreach (w[i]) for (int b = 3; b >= 0; b--) f.push_back(w[i][8 * b +: 8]);
        f.push_back(status);
        sum = 8'h00;
        for (int i = 2; i < f.size(); i++) sum = sum + f[i];
        f.push_back(sum);
        foreach (f[i]) exp_q.push_back(f[i]);
    endtask

    always @(posedge system_clk) begin
        #1;
        cyc++;
        tx_ready = ready_toggle ? (cyc % 3 == 0) : 1'b1;
    end

    // BRAM model: data returns two cycles after the read strobe.
    always begin
        @(negedge system_clk);
        if (bram_read_run && bram_on) begin
            rd_addr = bram_addr;
            @(posedge system_clk); #1;
            @(posedge system_clk); #1;
            bram_read_valid = 1'b1;
            bram_rdata = bram_word(rd_addr);
            @(posedge system_clk); #1;
            bram_read_valid = 1'b0;
            bram_rdata = 32'h0;
        end
    end

    always @(negedge system_clk) begin
        if (frame_done) done_cnt++;
        if (tx_valid && reset) begin
            valid_cycles++;
            if (stall_prev) check("stall_stable", tx_data, prev_data);
            if (tx_ready) begin
                got_q.push_back(tx_data);
                tests++;
                if (exp_q.size() == 0) begin
                    fails++;
                    $display("FAIL unexpected_byte: got %0h expected none", tx_data);
                end else begin
                    tests--;
                    check("frame_byte", tx_data, exp_q.pop_front());
                end
            end
            stall_prev = !tx_ready;
            prev_data  = tx_data;
        end else begin
            stall_prev = 1'b0;
        end
    end

    task automatic step();
        @(posedge system_clk);
        #1;
    endtask

    task automatic request(input logic [2:0] mode, input logic [7:0] status);
        send_request  = 1'b1;
        tracking_mode = mode;
        status_in     = status;
        step();
        send_request  = 1'b0;
    endtask

    task automatic wait_done();
        bit ok = 1'b0;
        for (int i = 0; i < 400; i++) begin
            @(negedge system_clk);
            if (frame_done) begin
                ok = 1'b1;
                break;
            end
        end
        check("frame_done_seen", ok, 1);
    endtask

    task automatic check_literal(input string name);
        check({name, "_len"}, got_q.size(), lit.size());
        if (got_q.size() == lit.size())
            foreach (lit[i]) check(name, got_q[i], lit[i]);
    endtask

    initial begin
        int n;
        int vc0;
        int d0;
        bit ok;
        mem_az    = 32'h0001_2345;
        mem_el    = 32'h0000_0ABC;
        mem_range = 32'h0100_0001;
`ifdef TRACKING_FRAME_TX_RANGE_EN
        lit = '{8'h55, 8'hAA, 8'h01, 8'h00, 8'h01, 8'h23, 8'h45, 8'h00, 8'h00, 8'h0A, 8'hBC,
                8'h01, 8'h00, 8'h00, 8'h01, 8'h80, 8'hB2};
`else
        lit = '{8'h55, 8'hAA, 8'h01, 8'h00, 8'h01, 8'h23, 8'h45, 8'h00, 8'h00, 8'h0A, 8'hBC,
                8'h80, 8'hB0};
`endif
        repeat (3) step();
        check("rst_tx_valid", tx_valid, 0);
        check("rst_busy", busy, 0);
        check("rst_frame_done", frame_done, 0);
        check("rst_read_run", bram_read_run, 0);
        check("rst_error", tx_error_bit, 0);
        check("rst_tx_data", tx_data, 0);
        reset = 1'b1;
        step();

        // Basic frame, tx_ready held high.
        got_q.delete();
        push_frame(8'h01, 8'h80);
        check("idle_busy", busy, 0);
        request(3'd1, 8'h80);
        check("lat_read_run", bram_read_run, 1);
        check("lat_addr_az", bram_addr, 10'd14);
        check("lat_busy", busy, 1);
        wait_done();
        step();
        check("t1_done_pulse", frame_done, 0);
        check("t1_busy", busy, 0);
        check("t1_error", tx_error_bit, 0);
        check("t1_tx_valid", tx_valid, 0);
        check("t1_done_cnt", done_cnt, 1);
        check("t1_exp_empty", exp_q.size(), 0);
        check_literal("t1_literal");

        // Same frame with back-pressure.
        ready_toggle = 1'b1;
        got_q.delete();
        push_frame(8'h01, 8'h80);
        request(3'd1, 8'h80);
        wait_done();
        ready_toggle = 1'b0;
        step();
        check("t2_done_cnt", done_cnt, 2);
        check("t2_exp_empty", exp_q.size(), 0);
        check_literal("t2_literal");

        // Read timeout.
        bram_on = 1'b0;
        vc0 = valid_cycles;
        d0  = done_cnt;
        request(3'd2, 8'h01);
        n = 0;
        while (busy && n < 50) begin
            n++;
            step();
        end
        check("t3_busy_cycles", n, 9);
        check("t3_error", tx_error_bit, 1);
        check("t3_busy", busy, 0);
        check("t3_no_valid", valid_cycles, vc0);
        check("t3_no_done", done_cnt, d0);
        repeat (3) step();
        check("t3_error_held", tx_error_bit, 1);
        bram_on = 1'b1;

        // Request dropped mid-SEND; checksum wraps.
        mem_az = 32'hFFFF_FFFF;
        mem_el = 32'h8000_0001;
        got_q.delete();
        d0 = done_cnt;
        push_frame(8'h03, 8'h12);
        request(3'd3, 8'h12);
        ok = 1'b0;
        for (int i = 0; i < 100 && !ok; i++) begin
            step();
            ok = tx_valid;
        end
        check("t4_send_reached", ok, 1);
        step();
        step();
        request(3'd4, 8'h77);
        check("t4_dropped", tx_error_bit, 2);
        check("t4_still_busy", busy, 1);
        wait_done();
        step();
        check("t4_error_cleared", tx_error_bit, 0);
        repeat (20) step();
        check("t4_busy", busy, 0);
        check("t4_done_cnt", done_cnt, d0 + 1);
        check("t4_exp_empty", exp_q.size(), 0);
        check("t4_len", got_q.size(), FLEN);
        if (got_q.size() == FLEN)
            check("t4_checksum", got_q[FLEN-1], (NW == 3) ? 8'h94 : 8'h92);

        // Reset asserted while byte 5 is on the bus.
        mem_az = 32'h0001_2345;
        mem_el = 32'h0000_0ABC;
        got_q.delete();
        push_frame(8'h04, 8'hFF);
        request(3'd4, 8'hFF);
        ok = 1'b0;
        for (int i = 0; i < 200 && !ok; i++) begin
            @(negedge system_clk);
            ok = (got_q.size() == 5);
        end
        check("t5_byte5_reached", ok, 1);
        #2;
        reset = 1'b0;
        #1;
        check("t5_async_valid", tx_valid, 0);
        check("t5_async_busy", busy, 0);
        exp_q.delete();
        repeat (2) step();
        reset = 1'b1;
        step();
        check("t5_error_after_rst", tx_error_bit, 0);
        check("t5_idle_valid", tx_valid, 0);
        got_q.delete();
        push_frame(8'h04, 8'hFF);
        request(3'd4, 8'hFF);
        wait_done();
        step();
        check("t5_exp_empty", exp_q.size(), 0);
        check("t5_len", got_q.size(), FLEN);
        if (got_q.size() == FLEN) begin
            check("t5_first", got_q[0], 8'h55);
            check("t5_checksum", got_q[FLEN-1], (NW == 3) ? 8'h34 : 8'h32);
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule
